// File: rtl/arbiter_pkg.sv
// Shared constants and state encoding for the 4-requester round-robin arbiter.
// The decoder-side bench imports this package for its expected-value checks.
package arbiter_pkg;
    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: the first set request at or after ptr, mod 4.
// The request vector is rotated so that ptr lands on bit 0, searched with fixed priority, then un-rotated.
module rr_pick4
    import arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        rot = (req >> ptr) | (req << (NREQ - int'(ptr)));
        off = '0;
        // Walk downwards so that the lowest set bit is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        idx = off + ptr;
        any = |req;
    end

endmodule

// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with grant hold, owner release and hold-limit timeout.
// Feeds a registered grant index and valid flag to the downstream 2-to-4 decoder.
module arbiter4_rr
    import arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (pick_any) begin
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    count_d = CNT_W'(1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Owner release outranks the hold limit, so a coincident done never flags a timeout.
                if (done || !req[idx_q]) begin
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 1'b1;
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (HOLD_MAX != 0 && count_q == HOLD_CNT) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    ptr_d     = idx_q + 1'b1;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else if (HOLD_MAX != 0) begin
                    count_d = count_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_arbiter4_rr.sv
// Scoreboard bench for arbiter4_rr: a cycle model pushes expected outputs as stimulus is driven,
// and they are popped and compared one clock later, alongside directed checks of the key scenarios.
module tb_arbiter4_rr;

    localparam int HM = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    arbiter4_rr #(.HOLD_MAX(HM)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic m_busy = 1'b0;
    int   m_ptr  = 0;
    int   m_idx  = 0;
    logic m_vld  = 1'b0;
    logic m_to   = 1'b0;
    int   m_cnt  = 0;

    int vld_cnt;
    int to_cnt;

    task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] req_v);
        n_tests++;
        if (obs !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, req_v, $time);
        end
    endtask

    task automatic model(input logic rst_i, input logic [3:0] r, input logic d);
        bit found;
        if (rst_i) begin
            m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_vld = 1'b0; m_to = 1'b0; m_cnt = 0;
        end else if (!m_busy) begin
            m_to  = 1'b0;
            m_vld = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found  = 1'b1;
                    m_idx  = (m_ptr + k) % 4;
                    m_vld  = 1'b1;
                    m_cnt  = 1;
                    m_busy = 1'b1;
                end
            end
        end else begin
            if (d || !r[m_idx]) begin
                m_to = 1'b0;
                m_vld = 1'b0; m_ptr = (m_idx + 1) % 4; m_busy = 1'b0; m_cnt = 0;
            end else if (HM != 0 && m_cnt == HM) begin
                m_to = 1'b1;
                m_vld = 1'b0; m_ptr = (m_idx + 1) % 4; m_busy = 1'b0; m_cnt = 0;
            end else begin
                m_to = 1'b0;
                m_cnt++;
            end
        end
    endtask

    // One clock: drive on the falling edge, predict, then compare just after the rising edge.
    task automatic step(input logic rst_i, input logic [3:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        reset = rst_i;
        req   = r;
        done  = d;
        model(rst_i, r, d);
        e.idx = 2'(m_idx);
        e.vld = m_vld;
        e.to  = m_to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_eq("sb_idx", 8'(grant_idx), 8'(e.idx));
        chk_eq("sb_valid", 8'(grant_valid), 8'(e.vld));
        chk_eq("sb_timeout", 8'(timeout), 8'(e.to));
    endtask

    initial begin
        // Reset, then idle
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 1'b0);
            chk_eq("idle_valid", 8'(grant_valid), 8'd0);
            chk_eq("idle_idx", 8'(grant_idx), 8'd0);
            chk_eq("idle_timeout", 8'(timeout), 8'd0);
        end

        // Rotation with all requesting and done one cycle into each grant
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 4'b1111, 1'b0);
            chk_eq("rot_valid", 8'(grant_valid), 8'd1);
            chk_eq("rot_idx", 8'(grant_idx), 8'(g % 4));
            step(1'b0, 4'b1111, 1'b1);
            chk_eq("rot_gap", 8'(grant_valid), 8'd0);
        end

        // Priority pointer and wrap
        step(1'b0, 4'b0010, 1'b0);
        chk_eq("ptr_first", 8'(grant_idx), 8'd1);
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        chk_eq("ptr_to3", 8'(grant_idx), 8'd3);
        step(1'b0, 4'b1001, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        chk_eq("ptr_wrap0", 8'(grant_idx), 8'd0);
        step(1'b0, 4'b1001, 1'b1);

        // Timeout: hold for HM cycles, one-cycle pulse, then regrant of 2
        vld_cnt = 0;
        to_cnt  = 0;
        for (int i = 0; i < HM + 1; i++) begin
            step(1'b0, 4'b0100, 1'b0);
            if (grant_valid) vld_cnt++;
            if (timeout) to_cnt++;
        end
        chk_eq("to_hold_cycles", 8'(vld_cnt), 8'(HM));
        chk_eq("to_pulse", 8'(timeout), 8'd1);
        chk_eq("to_pulses", 8'(to_cnt), 8'd1);
        step(1'b0, 4'b0100, 1'b0);
        chk_eq("to_regrant_v", 8'(grant_valid), 8'd1);
        chk_eq("to_regrant_idx", 8'(grant_idx), 8'd2);
        chk_eq("to_pulse_end", 8'(timeout), 8'd0);
        step(1'b0, 4'b0100, 1'b1);

        // done coinciding with the hold limit is a normal release
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        chk_eq("sim_held", 8'(grant_valid), 8'd1);
        step(1'b0, 4'b0100, 1'b1);
        chk_eq("sim_release", 8'(grant_valid), 8'd0);
        chk_eq("sim_no_timeout", 8'(timeout), 8'd0);

        // Reset mid-grant clears ptr
        step(1'b0, 4'b0010, 1'b0);
        chk_eq("mid_grant", 8'(grant_idx), 8'd1);
        step(1'b1, 4'b0010, 1'b0);
        chk_eq("mid_reset_v", 8'(grant_valid), 8'd0);
        step(1'b0, 4'b1111, 1'b0);
        chk_eq("mid_after_idx", 8'(grant_idx), 8'd0);
        chk_eq("mid_after_v", 8'(grant_valid), 8'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        chk_eq("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
